// File: rtl/riscV_unrn_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// STATUS bit layout, transmit FSM states and the MemoryBus command/result types.
package riscV_unrn_pkg;

    localparam logic [1:0] UART_TXDATA_OFS  = 2'd0;
    localparam logic [1:0] UART_STATUS_OFS  = 2'd1;
    localparam logic [1:0] UART_BAUDDIV_OFS = 2'd2;

    localparam int UART_STATUS_BUSY_BIT  = 0;
    localparam int UART_STATUS_FULL_BIT  = 1;
    localparam int UART_STATUS_EMPTY_BIT = 2;
    localparam int UART_STATUS_OVF_BIT   = 3;
    localparam int UART_STATUS_LEVEL_LSB = 4;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;

    typedef struct packed {
        logic        mem_read;
        logic [3:0]  mask_byte;
        logic [31:0] write_data;
    } mem_bus_cmd_t;

    typedef logic [31:0] mem_bus_result_t;

    // The STATUS level field is 4 bits wide; deeper buffers report 15.
    function automatic logic [3:0] uart_sat_level(input int unsigned level);
        return (level > 15) ? 4'hF : 4'(level);
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO for the UART transmitter: power-of-2 depth, simultaneous push/pop
// accepted when full, exposes fill level and head entry.
module uart_tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               push_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic [7:0]               head
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // NOTE: storage has no reset; the pointers and level define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_slave.sv
// Memory-mapped 8N1 UART transmitter (slave 2, 4-word window). Define
// UART_TX_FIFO_EN for a FIFO_DEPTH-entry buffer; otherwise one holding register.
module uart_tx_slave
    import riscV_unrn_pkg::*;
#(
    parameter int DEFAULT_DIV = 434,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      bus_address,
    input  logic            we,
    input  mem_bus_cmd_t    cmd,
    output mem_bus_result_t result,
    output logic            tx,
    output logic            tx_busy
);

    logic           push_req;
    logic           pop;
    logic           buf_full;
    logic           buf_empty;
    logic [7:0]     buf_head;
    int unsigned    fill;
    logic           overflow;
    logic [15:0]    baud_div;
    logic [15:0]    baud_wr;
    logic [15:0]    frame_div;
    logic [15:0]    bit_cnt;
    logic [2:0]     bit_idx;
    logic [7:0]     shift;
    logic [7:0]     status;
    logic           bit_done;
    uart_tx_state_t state;
    logic           unused_cmd;

    assign unused_cmd = &{1'b0, cmd.write_data[31:16], cmd.mask_byte[3:2]};

    assign push_req = we && (bus_address == UART_TXDATA_OFS) && cmd.mask_byte[0];
    assign bit_done = (bit_cnt == 16'd1);
    // The FSM pops from IDLE, or at the end of a stop bit for back-to-back frames.
    assign pop      = !buf_empty && ((state == IDLE) || ((state == STOP) && bit_done));
    assign tx_busy  = (state != IDLE) || !buf_empty;

`ifdef UART_TX_FIFO_EN
    logic [$clog2(FIFO_DEPTH):0] fifo_level;

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_req),
        .pop       (pop),
        .push_data (cmd.write_data[7:0]),
        .full      (buf_full),
        .empty     (buf_empty),
        .level     (fifo_level),
        .head      (buf_head)
    );

    assign fill = 32'(fifo_level);
`else
    localparam int unused_fifo_depth = FIFO_DEPTH;

    logic       hold_valid;
    logic [7:0] hold_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
        end else if (push_req && (!hold_valid || pop)) begin
            hold_valid <= 1'b1;
            hold_data  <= cmd.write_data[7:0];
        end else if (pop) begin
            hold_valid <= 1'b0;
        end
    end

    assign buf_full  = hold_valid;
    assign buf_empty = !hold_valid;
    assign buf_head  = hold_data;
    assign fill      = hold_valid ? 32'd1 : 32'd0;
`endif

    assign baud_wr = {cmd.mask_byte[1] ? cmd.write_data[15:8] : baud_div[15:8],
                      cmd.mask_byte[0] ? cmd.write_data[7:0]  : baud_div[7:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
            baud_div <= 16'(DEFAULT_DIV);
        end else begin
            if (push_req && buf_full && !pop)
                overflow <= 1'b1;
            else if (we && (bus_address == UART_STATUS_OFS) && cmd.mask_byte[0]
                     && cmd.write_data[UART_STATUS_OVF_BIT])
                overflow <= 1'b0;
            if (we && (bus_address == UART_BAUDDIV_OFS))
                baud_div <= (baud_wr == 16'd0) ? 16'd1 : baud_wr;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        status = '0;
        status[UART_STATUS_BUSY_BIT]  = tx_busy;
        status[UART_STATUS_FULL_BIT]  = buf_full;
        status[UART_STATUS_EMPTY_BIT] = buf_empty;
        status[UART_STATUS_OVF_BIT]   = overflow;
        status[UART_STATUS_LEVEL_LSB +: 4] = uart_sat_level(fill);

        result = '0;
        if (cmd.mem_read) begin
            case (bus_address)
                UART_STATUS_OFS:  result = {24'd0, status};
                UART_BAUDDIV_OFS: result = {16'd0, baud_div};
                default:          result = '0;
            endcase
        end
    end

    // Frame divisor is captured at each frame start so mid-frame BAUDDIV writes wait.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tx        <= 1'b1;
            shift     <= '0;
            bit_cnt   <= 16'd1;
            frame_div <= 16'd1;
            bit_idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        shift     <= buf_head;
                        frame_div <= baud_div;
                        bit_cnt   <= baud_div;
                        tx        <= 1'b0;
                        state     <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        bit_cnt <= frame_div;
                        bit_idx <= '0;
                        tx      <= shift[0];
                        state   <= DATA;
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        bit_cnt <= frame_div;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            shift <= shift >> 1;
                            tx    <= shift[1];
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        if (pop) begin
                            shift     <= buf_head;
                            frame_div <= baud_div;
                            bit_cnt   <= baud_div;
                            tx        <= 1'b0;
                            state     <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_slave.sv
// Scoreboard bench for uart_tx_slave: stimulus queues expected frames, a serial
// monitor decodes tx cycle by cycle and compares each frame against the queue.
module tb_uart_tx_slave;
    import riscV_unrn_pkg::*;

`ifdef UART_TX_FIFO_EN
    localparam int          N_ACC      = 9;
    localparam logic [31:0] OVF_STATUS = 32'h8B;
    localparam logic [31:0] CLR_STATUS = 32'h83;
`else
    localparam int          N_ACC      = 2;
    localparam logic [31:0] OVF_STATUS = 32'h1B;
    localparam logic [31:0] CLR_STATUS = 32'h13;
`endif

    typedef struct {
        logic [7:0] data;
        int         div;
    } frame_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      bus_address;
    logic            we;
    mem_bus_cmd_t    cmd;
    mem_bus_result_t result;
    logic            tx;
    logic            tx_busy;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          last_wr_cyc = 0;
    logic [31:0] rd;
    int          zeros;

    frame_t exp_q[$];
    int     start_q[$];
    bit     mon_busy = 1'b0;

    frame_t     mon_f;
    logic [7:0] mon_got;
    int         mon_bad;
    bit         mon_abort;
    logic       mon_e;
    logic       prev_tx = 1'b1;

    uart_tx_slave #(.DEFAULT_DIV(434), .FIFO_DEPTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus_address (bus_address),
        .we          (we),
        .cmd         (cmd),
        .result      (result),
        .tx          (tx),
        .tx_busy     (tx_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] m);
        bus_address        = a;
        we                 = 1'b1;
        cmd.mem_read       = 1'b0;
        cmd.mask_byte      = m;
        cmd.write_data     = d;
        @(posedge clk);
        @(negedge clk);
        last_wr_cyc        = cyc;
        we                 = 1'b0;
        cmd.mask_byte      = 4'h0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        bus_address  = a;
        cmd.mem_read = 1'b1;
        #1;
        d            = result;
        cmd.mem_read = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int div, input bit expect_tx);
        if (expect_tx)
            exp_q.push_back('{data: b, div: div});
        bus_write(UART_TXDATA_OFS, {24'd0, b}, 4'b0001);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || mon_busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL drain_timeout: %0d frames pending after %0d cycles, required 0", exp_q.size(), n);
        end
        repeat (2) @(negedge clk);
    endtask

    // Serial monitor: checks every cycle of each frame, so bit widths are exact.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!rst && prev_tx && tx == 1'b0) begin
                start_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_frame: start bit at cycle %0d, required no frame", cyc);
                end else begin
                    mon_busy  = 1'b1;
                    mon_f     = exp_q.pop_front();
                    mon_got   = '0;
                    mon_bad   = 0;
                    mon_abort = 1'b0;
                    for (int b = 0; b < 10 && !mon_abort; b++) begin
                        for (int c = 0; c < mon_f.div && !mon_abort; c++) begin
                            if (!(b == 0 && c == 0))
                                @(negedge clk);
                            if (rst) begin
                                mon_abort = 1'b1;
                            end else begin
                                mon_e = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : mon_f.data[b-1];
                                if (tx !== mon_e)
                                    mon_bad++;
                                if (c == mon_f.div / 2 && b >= 1 && b <= 8)
                                    mon_got[b-1] = tx;
                            end
                        end
                    end
                    if (mon_abort) begin
                        while (rst) @(negedge clk);
                    end else begin
                        check("frame_data", {24'd0, mon_got}, {24'd0, mon_f.data});
                        check("frame_bit_cycles_wrong", mon_bad, 0);
                    end
                    mon_busy = 1'b0;
                end
            end
            prev_tx = tx;
        end
    end

    initial begin
        rst         = 1'b1;
        we          = 1'b0;
        bus_address = 2'd0;
        cmd         = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state and register map
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_tx_busy", {31'd0, tx_busy}, 32'd0);
        bus_read(UART_STATUS_OFS, rd);
        check("reset_status", rd, 32'h4);
        bus_read(UART_BAUDDIV_OFS, rd);
        check("reset_bauddiv", rd, 32'd434);
        bus_address = UART_STATUS_OFS;
        #1;
        check("result_without_read", result, 32'd0);
        bus_read(UART_TXDATA_OFS, rd);
        check("txdata_reads_zero", rd, 32'd0);
        bus_read(2'd3, rd);
        check("reserved_reads_zero", rd, 32'd0);
        @(negedge clk);

        // Single frame, DIV=4
        bus_write(UART_BAUDDIV_OFS, 32'd4, 4'b0011);
        bus_read(UART_BAUDDIV_OFS, rd);
        check("bauddiv_4", rd, 32'd4);
        @(negedge clk);
        start_q.delete();
        send(8'hA5, 4, 1'b1);
        wait_drain(200);
        check("a5_start_count", start_q.size(), 1);
        if (start_q.size() >= 1)
            check("push_to_start_latency", start_q[0] - last_wr_cyc, 1);
        bus_read(UART_STATUS_OFS, rd);
        check("status_after_a5", rd, 32'h4);
        @(negedge clk);

        // Back-to-back frames, DIV=2
        bus_write(UART_BAUDDIV_OFS, 32'd2, 4'b0011);
        start_q.delete();
        send(8'h55, 2, 1'b1);
        send(8'h0F, 2, 1'b1);
        wait_drain(200);
        check("b2b_start_count", start_q.size(), 2);
        if (start_q.size() >= 2)
            check("b2b_start_spacing", start_q[1] - start_q[0], 20);
        bus_read(UART_STATUS_OFS, rd);
        check("status_after_b2b", rd, 32'h4);
        @(negedge clk);

        // Overflow with DIV=100
        bus_write(UART_BAUDDIV_OFS, 32'd100, 4'b0011);
        for (int i = 0; i < 10; i++)
            send(8'h10 + 8'(i), 100, i < N_ACC);
        bus_read(UART_STATUS_OFS, rd);
        check("status_overflow", rd, OVF_STATUS);
        @(negedge clk);
        bus_write(UART_STATUS_OFS, 32'h8, 4'b0001);
        bus_read(UART_STATUS_OFS, rd);
        check("status_ovf_cleared", rd, CLR_STATUS);
        @(negedge clk);
        wait_drain(12000);
        bus_read(UART_STATUS_OFS, rd);
        check("status_after_overflow_drain", rd, 32'h4);
        @(negedge clk);

        // BAUDDIV=0 is stored as 1; byte-masked write to the high byte
        bus_write(UART_BAUDDIV_OFS, 32'd0, 4'b0011);
        bus_read(UART_BAUDDIV_OFS, rd);
        check("bauddiv_zero_as_one", rd, 32'd1);
        @(negedge clk);
        send(8'h3C, 1, 1'b1);
        wait_drain(100);
        bus_write(UART_BAUDDIV_OFS, 32'hAB03_FF00, 4'b0010);
        bus_read(UART_BAUDDIV_OFS, rd);
        check("bauddiv_byte_mask", rd, 32'hFF01);
        @(negedge clk);

        // Reset in the middle of DATA
        bus_write(UART_BAUDDIV_OFS, 32'd10, 4'b0011);
        send(8'hC3, 10, 1'b1);
        repeat (36) @(negedge clk);
        check("in_frame_before_reset", {31'd0, mon_busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("reset_async_tx", {31'd0, tx}, 32'd1);
        bus_read(UART_STATUS_OFS, rd);
        check("status_in_reset", rd, 32'h4);
        bus_read(UART_BAUDDIV_OFS, rd);
        check("bauddiv_in_reset", rd, 32'd434);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        zeros = 0;
        repeat (300) begin
            @(negedge clk);
            if (tx !== 1'b1)
                zeros++;
        end
        check("no_bits_after_reset", zeros, 0);
        check("tx_busy_after_reset", {31'd0, tx_busy}, 32'd0);
        check("frames_outstanding", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
